// File: rtl/wave_playback_reader.sv
// ============================================================================
// Module      : wave_playback_reader
// Description : Plays a span of wide words out of a registered-read waveform
//               RAM onto a valid/ready stream, absorbing the RAM read latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wave_playback_reader #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_read_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   c_LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   c_LEN_ZERO = '0;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic [DATA_WIDTH-1:0] r_buf_data [2];
    logic [1:0]            r_buf_last;
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [1:0]            r_count;
    logic                  r_done;

    logic                  w_pop;
    logic [2:0]            w_pending;
    logic                  w_issue;
    logic                  w_last_pop;

    assign w_pop      = (r_count != 2'd0) & out_ready;
    assign w_last_pop = w_pop & r_buf_last[r_rd_ptr];
    // Words already buffered or on their way, net of the word leaving this edge.
    assign w_pending  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue    = (r_state == c_RUN) && (r_remaining != c_LEN_ZERO) && (w_pending < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= c_IDLE;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_buf_data[i] <= '0;
            end
            r_buf_last      <= 2'b00;
            r_rd_ptr        <= 1'b0;
            r_wr_ptr        <= 1'b0;
            r_count         <= 2'd0;
            r_done          <= 1'b0;
        end else if (abort) begin
            r_state         <= c_IDLE;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_rd_ptr        <= 1'b0;
            r_wr_ptr        <= 1'b0;
            r_count         <= 2'd0;
            r_done          <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // RAM word for the read issued last edge is valid now.
            if (r_inflight) begin
                r_buf_data[r_wr_ptr] <= ram_read_data;
                r_buf_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};

            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remaining == c_LEN_ONE);
            if (w_issue) begin
                r_addr      <= r_addr + c_ADDR_ONE;
                r_remaining <= r_remaining - c_LEN_ONE;
            end

            case (r_state)
                c_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_len == c_LEN_ZERO) begin
                            r_done <= 1'b1;
                        end else begin
                            r_addr      <= cmd_addr;
                            r_remaining <= cmd_len;
                            r_state     <= c_RUN;
                        end
                    end
                end
                c_RUN: begin
                    if (w_issue && (r_remaining == c_LEN_ONE)) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    if (w_last_pop) begin
                        r_state <= c_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = (r_state == c_IDLE);
    assign busy          = (r_state != c_IDLE);
    assign done          = r_done;
    assign ram_read_addr = r_addr;
    assign out_valid     = (r_count != 2'd0);
    assign out_data      = r_buf_data[r_rd_ptr];
    assign out_last      = r_buf_last[r_rd_ptr] & out_valid;

endmodule

`default_nettype wire
